ex_mm_stage: RTL and testbench
==============================

# ex_mm_stage

Parametrised EX→MEM pipeline stage: registers the execute-stage result, register-write request, memory-op descriptor and branch-redirect info into the memory stage. It replaces the single-phase stall register with a valid/ready elastic handshake, an optional 2-entry skid buffer, a flush input and a saturating back-pressure counter. The redirect path is registered on the rising edge; there is no negedge logic. Sits between the ALU/branch unit (upstream) and the load/store unit (downstream); the redirect output feeds the fetch PC mux.

## Interface
Parameters:
- XLEN, 32: data/address width.
- RA_W, 5: register-address width.
- MOP_W, 5: memory-op encoding width; 0 means no memory op.
- SKID, 1: 1 selects the 2-entry skid buffer with registered `ex_ready`; 0 selects a single register with combinational `ex_ready`.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill all held and incoming entries.
- ex_valid  in  1  upstream entry valid.
- ex_ready  out  1  stage can accept this cycle.
- ex_wa  in  RA_W  destination register.
- ex_we  in  1  register write enable.
- ex_wn  in  XLEN  result data.
- ex_mem_e  in  MOP_W  memory-op code.
- ex_mem_n  in  XLEN  store data.
- ex_br_taken  in  1  entry redirects fetch.
- ex_br_pc  in  XLEN  redirect target.
- mm_valid  out  1  downstream entry valid.
- mm_ready  in  1  downstream accepts.
- mm_wa  out  RA_W  registered `ex_wa`.
- mm_we  out  1  registered `ex_we`.
- mm_wn  out  XLEN  registered `ex_wn`.
- mm_mem_e  out  MOP_W  registered `ex_mem_e`.
- mm_mem_n  out  XLEN  registered `ex_mem_n`.
- redirect_valid  out  1  one-cycle fetch-redirect pulse.
- redirect_pc  out  XLEN  redirect target.
- stall_cnt  out  CNT_W  cycles with `mm_valid && !mm_ready`; saturates.

## Operation
- Accept: `acc = ex_valid && ex_ready && !flush`. Transfer out: `mm_valid && mm_ready`.
- SKID=0:
  - `ex_ready = !mm_valid || mm_ready`, combinational.
  - On `acc`, the main register loads the payload.
  - On transfer without `acc`, `mm_valid` clears.
- SKID=1:
  - State is main register M plus skid register S. States: EMPTY (M empty), ONE (M full, S empty), TWO (M and S full).
  - `ex_ready = !S_full`, registered.
  - EMPTY: `acc` → ONE.
  - ONE:
    - `acc` with transfer → ONE (M takes the new entry).
    - `acc` without transfer → TWO (new entry goes to S).
    - Transfer without `acc` → EMPTY.
  - TWO: transfer → ONE (S moves to M); no accept possible.
- Entries leave in order.
- Bubble-clean outputs: when `mm_valid=0`, `mm_we=0` and `mm_mem_e=0`. `mm_wa`, `mm_wn` and `mm_mem_n` hold their last values.
- Redirect:
  - On `acc` with `ex_br_taken=1`, `redirect_valid=1` and `redirect_pc=ex_br_pc` the next cycle, for exactly one cycle.
  - The redirect is independent of downstream back-pressure.
- Flush:
  - Next state EMPTY; S cleared; incoming entry dropped.
  - `redirect_valid` is 0 next cycle, overriding a same-cycle branch accept.
  - `ex_ready` is 1 next cycle.
- stall_cnt: increments each cycle `mm_valid && !mm_ready` holds, saturates at 2^CNT_W−1, not cleared by flush.
- Reset values:
  - `mm_valid=0`, `mm_we=0`, `mm_wa=0`, `mm_wn=0`, `mm_mem_e=0`, `mm_mem_n=0`.
  - `redirect_valid=0`, `redirect_pc=0`, `stall_cnt=0`.
  - `ex_ready=1`; internal state EMPTY.

## Timing
- Latency: accept in cycle N → `mm_valid` in N+1 when M is empty or draining in N.
- SKID=1: `ex_ready` falls the cycle after S fills and rises the cycle after S drains into M. Accept throughput is one entry per cycle while `mm_ready=1`.
- SKID=0: throughput is one per cycle; `ex_ready` has a combinational path from `mm_ready`.
- Simultaneous accept and transfer in ONE keeps occupancy unchanged.
- Upstream must hold `ex_valid` and the payload stable while `ex_ready=0`.
- Asynchronous `rst` mid-transfer drops all entries immediately. The first accept is possible in the first clock edge after deassertion.

## Test plan
- Streaming, SKID=1, `mm_ready=1`: 4 entries with `ex_wn`=1..4 → `mm_wn`=1..4 on consecutive cycles, each one cycle after accept; `ex_ready` stays 1.
- Back-pressure, SKID=1: `mm_ready=0` for 5 cycles while `ex_valid=1`:
  - Skid fills and `ex_ready=0` from the 3rd cycle.
  - `stall_cnt=4` at the end of the window.
  - Releasing `mm_ready` delivers both entries in order with none lost or duplicated.
- Bubble-clean: accept `ex_we=1, ex_mem_e=3`, then transfer with no new input → next cycle `mm_valid=0`, `mm_we=0`, `mm_mem_e=0`.
- Redirect:
  - Accept `ex_br_taken=1, ex_br_pc=32'h100` while `mm_ready=0` → `redirect_valid=1`, `redirect_pc=32'h100` for exactly one cycle.
  - Repeat with `flush=1` in the accept cycle → `redirect_valid` stays 0.
- Flush in TWO state → next cycle `mm_valid=0`, `ex_ready=1`; `stall_cnt` is unchanged by the flush.
- SKID=0: `mm_valid=1, mm_ready=0` → `ex_ready=0` in the same cycle; raising `mm_ready` raises `ex_ready` in the same cycle.
- Reset: assert `rst` asynchronously between clock edges → all outputs go to their reset values before the next edge; `stall_cnt=0`.

Source files
------------

// File: rtl/ex_mm_stage.sv
// ex_mm_stage: EX->MEM pipeline stage with a valid/ready elastic handshake.
//
// Registers the execute result, register-write request and memory-op descriptor
// into the memory stage. It also produces a registered one-cycle branch redirect
// pulse for the fetch PC mux.
//
// Parameters
//   XLEN  : data/address width
//   RA_W  : register-address width
//   MOP_W : memory-op code width (0 = no memory op)
//   SKID  : 1 = 2-entry skid buffer, registered ex_ready
//           0 = single register, combinational ex_ready
//   CNT_W : back-pressure counter width
//
// Ports
//   clk, rst (async, active-high), flush
//   ex_*     : upstream handshake (ex_valid/ex_ready) and payload
//   mm_*     : downstream handshake (mm_valid/mm_ready) and registered payload
//   redirect_valid / redirect_pc : registered fetch redirect
//   stall_cnt                    : saturating count of mm_valid && !mm_ready cycles

module ex_mm_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned MOP_W = 5,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [RA_W-1:0]  ex_wa,
    input  logic             ex_we,
    input  logic [XLEN-1:0]  ex_wn,
    input  logic [MOP_W-1:0] ex_mem_e,
    input  logic [XLEN-1:0]  ex_mem_n,
    input  logic             ex_br_taken,
    input  logic [XLEN-1:0]  ex_br_pc,
    output logic             mm_valid,
    input  logic             mm_ready,
    output logic [RA_W-1:0]  mm_wa,
    output logic             mm_we,
    output logic [XLEN-1:0]  mm_wn,
    output logic [MOP_W-1:0] mm_mem_e,
    output logic [XLEN-1:0]  mm_mem_n,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    // Payload packing: {wa, we, wn, mem_e, mem_n}
    localparam int unsigned PW = RA_W + 1 + XLEN + MOP_W + XLEN;

    // Occupancy: EMPTY (M empty), ONE (M full), TWO (M and S full)
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    m_q, m_d;
    logic [PW-1:0]    s_q, s_d;
    logic             ex_ready_q, ex_ready_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [PW-1:0]    in_pl;
    logic             acc;
    logic             xfer;

    logic [RA_W-1:0]  m_wa;
    logic             m_we;
    logic [XLEN-1:0]  m_wn;
    logic [MOP_W-1:0] m_mem_e;
    logic [XLEN-1:0]  m_mem_n;

    assign in_pl = {ex_wa, ex_we, ex_wn, ex_mem_e, ex_mem_n};
    assign {m_wa, m_we, m_wn, m_mem_e, m_mem_n} = m_q;

    assign mm_valid = (state_q != StEmpty);
    assign ex_ready = (SKID != 0) ? ex_ready_q : (!mm_valid || mm_ready);

    assign acc  = ex_valid && ex_ready && !flush;
    assign xfer = mm_valid && mm_ready;

    // Bubble-clean: side-effecting fields are forced to zero when no entry is held.
    assign mm_wa    = m_wa;
    assign mm_wn    = m_wn;
    assign mm_mem_n = m_mem_n;
    assign mm_we    = mm_valid && m_we;
    assign mm_mem_e = mm_valid ? m_mem_e : '0;

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall_cnt      = stall_cnt_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;

        if (SKID != 0) begin
            case (state_q)
                StEmpty: begin
                    if (acc) begin
                        m_d     = in_pl;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (acc && xfer) begin
                        m_d = in_pl;
                    end else if (acc) begin
                        s_d     = in_pl;
                        state_d = StTwo;
                    end else if (xfer) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // ex_ready is low here, so only a drain can happen
                    if (xfer) begin
                        m_d     = s_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end else begin
            if (acc) begin
                m_d     = in_pl;
                state_d = StOne;
            end else if (xfer) begin
                state_d = StEmpty;
            end
        end

        // Flush keeps M's last contents visible on the held-value outputs
        // rather than promoting the discarded skid entry.
        if (flush) begin
            state_d = StEmpty;
            m_d     = m_q;
            s_d     = '0;
        end
    end

    // Registered ready: low exactly while the skid register will be occupied.
    always_comb begin
        ex_ready_d = (state_d != StTwo);
    end

    always_comb begin
        redirect_valid_d = acc && ex_br_taken;
        redirect_pc_d    = redirect_valid_d ? ex_br_pc : redirect_pc_q;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (mm_valid && !mm_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StEmpty;
            m_q              <= '0;
            s_q              <= '0;
            ex_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stall_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            m_q              <= m_d;
            s_q              <= s_d;
            ex_ready_q       <= ex_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_ex_mm_stage.sv
// Bench for ex_mm_stage: one SKID=1 instance and one SKID=0 instance, each
// checked every cycle against a queue-based model of the stage occupancy.

module tb_ex_mm_stage;

    typedef struct packed {
        logic [4:0]  wa;
        logic        we;
        logic [31:0] wn;
        logic [4:0]  mem_e;
        logic [31:0] mem_n;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_valid, ex_valid0;
    logic        mm_ready, mm_ready0;
    logic [4:0]  ex_wa;
    logic        ex_we;
    logic [31:0] ex_wn;
    logic [4:0]  ex_mem_e;
    logic [31:0] ex_mem_n;
    logic        ex_br_taken;
    logic [31:0] ex_br_pc;

    logic        ex_ready, mm_valid, mm_we, redirect_valid;
    logic [4:0]  mm_wa, mm_mem_e;
    logic [31:0] mm_wn, mm_mem_n, redirect_pc;
    logic [15:0] stall_cnt;

    logic        ex_ready0, mm_valid0, mm_we0, redirect_valid0;
    logic [4:0]  mm_wa0, mm_mem_e0;
    logic [31:0] mm_wn0, mm_mem_n0, redirect_pc0;
    logic [15:0] stall_cnt0;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    ent_t        q1[$], q0[$];
    ent_t        shown1, shown0;
    logic        rv1, rv0;
    logic [31:0] rpc1, rpc0;
    logic [15:0] cnt1, cnt0;
    logic        hold1, hold0;
    logic [15:0] saved_cnt;

    always #5 clk = ~clk;

    ex_mm_stage #(.XLEN(32), .RA_W(5), .MOP_W(5), .SKID(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_wa(ex_wa), .ex_we(ex_we), .ex_wn(ex_wn),
        .ex_mem_e(ex_mem_e), .ex_mem_n(ex_mem_n),
        .ex_br_taken(ex_br_taken), .ex_br_pc(ex_br_pc),
        .mm_valid(mm_valid), .mm_ready(mm_ready),
        .mm_wa(mm_wa), .mm_we(mm_we), .mm_wn(mm_wn),
        .mm_mem_e(mm_mem_e), .mm_mem_n(mm_mem_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cnt(stall_cnt)
    );

    ex_mm_stage #(.XLEN(32), .RA_W(5), .MOP_W(5), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid0), .ex_ready(ex_ready0),
        .ex_wa(ex_wa), .ex_we(ex_we), .ex_wn(ex_wn),
        .ex_mem_e(ex_mem_e), .ex_mem_n(ex_mem_n),
        .ex_br_taken(ex_br_taken), .ex_br_pc(ex_br_pc),
        .mm_valid(mm_valid0), .mm_ready(mm_ready0),
        .mm_wa(mm_wa0), .mm_we(mm_we0), .mm_wn(mm_wn0),
        .mm_mem_e(mm_mem_e0), .mm_mem_n(mm_mem_n0),
        .redirect_valid(redirect_valid0), .redirect_pc(redirect_pc0),
        .stall_cnt(stall_cnt0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q0.delete();
        shown1 = '0;
        shown0 = '0;
        rv1 = 1'b0;
        rv0 = 1'b0;
        rpc1 = '0;
        rpc0 = '0;
        cnt1 = '0;
        cnt0 = '0;
        hold1 = 1'b0;
        hold0 = 1'b0;
    endtask

    task automatic check_all();
        bit f1, f0;
        f1 = (q1.size() != 0);
        f0 = (q0.size() != 0);
        if (f1) shown1 = q1[0];
        if (f0) shown0 = q0[0];
        chk("mm_valid", mm_valid, f1);
        chk("ex_ready", ex_ready, q1.size() < 2);
        chk("mm_wa", mm_wa, shown1.wa);
        chk("mm_we", mm_we, f1 ? shown1.we : 1'b0);
        chk("mm_wn", mm_wn, shown1.wn);
        chk("mm_mem_e", mm_mem_e, f1 ? shown1.mem_e : 5'd0);
        chk("mm_mem_n", mm_mem_n, shown1.mem_n);
        chk("redirect_valid", redirect_valid, rv1);
        chk("redirect_pc", redirect_pc, rpc1);
        chk("stall_cnt", stall_cnt, cnt1);
        chk("s0 mm_valid", mm_valid0, f0);
        chk("s0 ex_ready", ex_ready0, !f0 || mm_ready0);
        chk("s0 mm_wa", mm_wa0, shown0.wa);
        chk("s0 mm_we", mm_we0, f0 ? shown0.we : 1'b0);
        chk("s0 mm_wn", mm_wn0, shown0.wn);
        chk("s0 mm_mem_e", mm_mem_e0, f0 ? shown0.mem_e : 5'd0);
        chk("s0 mm_mem_n", mm_mem_n0, shown0.mem_n);
        chk("s0 redirect_valid", redirect_valid0, rv0);
        chk("s0 redirect_pc", redirect_pc0, rpc0);
        chk("s0 stall_cnt", stall_cnt0, cnt0);
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        ent_t cur;
        bit   r1, a1, x1, r0, a0, x0;
        cur = {ex_wa, ex_we, ex_wn, ex_mem_e, ex_mem_n};

        r1 = (q1.size() < 2);
        a1 = ex_valid && r1 && !flush;
        x1 = (q1.size() != 0) && mm_ready;
        if (q1.size() != 0 && !mm_ready && cnt1 != 16'hffff) cnt1++;
        rv1 = a1 && ex_br_taken;
        if (rv1) rpc1 = ex_br_pc;
        hold1 = ex_valid && !r1 && !flush;
        if (x1) void'(q1.pop_front());
        if (a1) q1.push_back(cur);
        if (flush) q1.delete();

        r0 = (q0.size() == 0) || mm_ready0;
        a0 = ex_valid0 && r0 && !flush;
        x0 = (q0.size() != 0) && mm_ready0;
        if (q0.size() != 0 && !mm_ready0 && cnt0 != 16'hffff) cnt0++;
        rv0 = a0 && ex_br_taken;
        if (rv0) rpc0 = ex_br_pc;
        hold0 = ex_valid0 && !r0 && !flush;
        if (x0) void'(q0.pop_front());
        if (a0) q0.push_back(cur);
        if (flush) q0.delete();
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    task automatic idle_inputs();
        flush = 0; ex_valid = 0; ex_valid0 = 0; mm_ready = 1; mm_ready0 = 1;
        ex_wa = 0; ex_we = 0; ex_wn = 0; ex_mem_e = 0; ex_mem_n = 0;
        ex_br_taken = 0; ex_br_pc = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #12;
        chk("reset ex_ready", ex_ready, 1'b1);
        chk("reset mm_valid", mm_valid, 1'b0);
        chk("reset stall_cnt", stall_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming with mm_ready=1
        for (int k = 1; k <= 4; k++) begin
            ex_valid = 1; ex_wa = 5'(k); ex_wn = 32'(k); ex_mem_n = 32'(k * 16);
            sample();
            chk("stream ex_ready", ex_ready, 1'b1);
            if (k > 1) chk("stream mm_wn", mm_wn, 32'(k - 1));
            adv();
        end
        ex_valid = 0;
        sample();
        chk("stream last mm_wn", mm_wn, 32'd4);
        chk("stream last mm_valid", mm_valid, 1'b1);
        adv();
        cyc();

        // Back-pressure: 5 cycles with mm_ready=0
        mm_ready = 0; ex_valid = 1; ex_wn = 32'd10;
        for (int i = 1; i <= 5; i++) begin
            sample();
            chk("bp ex_ready", ex_ready, i < 3);
            adv();
            if (i <= 2) ex_wn = ex_wn + 1;
        end
        mm_ready = 1;
        sample();
        chk("bp stall_cnt", stall_cnt, 16'd4);
        chk("bp first", mm_wn, 32'd10);
        adv();
        sample();
        chk("bp second", mm_wn, 32'd11);
        chk("bp ready back", ex_ready, 1'b1);
        adv();
        ex_valid = 0;
        sample();
        chk("bp third", mm_wn, 32'd12);
        adv();
        sample();
        chk("bp drained", mm_valid, 1'b0);
        adv();

        // Bubble-clean
        ex_valid = 1; ex_we = 1; ex_mem_e = 5'd3;
        cyc();
        ex_valid = 0;
        sample();
        chk("bubble we held", mm_we, 1'b1);
        chk("bubble mem_e held", mm_mem_e, 5'd3);
        adv();
        sample();
        chk("bubble valid", mm_valid, 1'b0);
        chk("bubble we", mm_we, 1'b0);
        chk("bubble mem_e", mm_mem_e, 5'd0);
        adv();
        ex_we = 0; ex_mem_e = 0;

        // Redirect under back-pressure
        mm_ready = 0; ex_valid = 1; ex_br_taken = 1; ex_br_pc = 32'h100;
        cyc();
        ex_valid = 0; ex_br_taken = 0;
        sample();
        chk("redir valid", redirect_valid, 1'b1);
        chk("redir pc", redirect_pc, 32'h100);
        adv();
        sample();
        chk("redir one cycle", redirect_valid, 1'b0);
        adv();
        mm_ready = 1;
        cyc();
        // Redirect killed by same-cycle flush
        ex_valid = 1; ex_br_taken = 1; ex_br_pc = 32'h200; flush = 1;
        cyc();
        ex_valid = 0; ex_br_taken = 0; flush = 0;
        sample();
        chk("redir flushed", redirect_valid, 1'b0);
        adv();

        // Flush in TWO
        mm_ready = 0; ex_valid = 1; ex_wn = 32'd20;
        cyc();
        ex_wn = 32'd21;
        cyc();
        ex_valid = 0;
        sample();
        chk("two ex_ready", ex_ready, 1'b0);
        adv();
        flush = 1;
        saved_cnt = cnt1;
        cyc();
        flush = 0;
        sample();
        chk("flush mm_valid", mm_valid, 1'b0);
        chk("flush ex_ready", ex_ready, 1'b1);
        chk("flush stall_cnt", stall_cnt, saved_cnt + 16'd1);
        adv();
        mm_ready = 1;

        // SKID=0 combinational ready
        ex_valid0 = 1; mm_ready0 = 0; ex_wn = 32'd33;
        cyc();
        ex_valid0 = 0;
        sample();
        chk("s0 ready low", ex_ready0, 1'b0);
        mm_ready0 = 1;
        #1;
        chk("s0 ready comb", ex_ready0, 1'b1);
        adv();
        cyc();

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            if (!hold1 && !hold0) begin
                ex_wa = 5'($urandom);
                ex_we = 1'($urandom);
                ex_wn = $urandom;
                ex_mem_e = 5'($urandom);
                ex_mem_n = $urandom;
                ex_br_taken = ($urandom_range(0, 3) == 0);
                ex_br_pc = $urandom;
            end
            ex_valid  = hold1 ? 1'b1 : ($urandom_range(0, 9) < 7);
            ex_valid0 = hold0 ? 1'b1 : ($urandom_range(0, 9) < 7);
            mm_ready  = ($urandom_range(0, 9) < 6);
            mm_ready0 = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            cyc();
        end

        // Asynchronous reset between edges
        ex_valid = 1; ex_valid0 = 1; mm_ready = 0; mm_ready0 = 0; flush = 0;
        cyc();
        cyc();
        #1;
        rst = 1'b1;
        #1;
        chk("arst mm_valid", mm_valid, 1'b0);
        chk("arst mm_we", mm_we, 1'b0);
        chk("arst mm_wa", mm_wa, 5'd0);
        chk("arst mm_wn", mm_wn, 32'd0);
        chk("arst mm_mem_e", mm_mem_e, 5'd0);
        chk("arst mm_mem_n", mm_mem_n, 32'd0);
        chk("arst redirect_valid", redirect_valid, 1'b0);
        chk("arst redirect_pc", redirect_pc, 32'd0);
        chk("arst stall_cnt", stall_cnt, 16'd0);
        chk("arst ex_ready", ex_ready, 1'b1);
        chk("arst s0 mm_valid", mm_valid0, 1'b0);
        model_reset();
        #1;
        rst = 1'b0;
        idle_inputs();
        ex_valid = 1; ex_wn = 32'd77;
        cyc();
        ex_valid = 0;
        sample();
        chk("post-reset accept", mm_wn, 32'd77);
        adv();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
